// File: rtl/arcade_input_pkg.sv
// Shared types and default timing constants for the arcade input conditioner.
// The coin state machine enum lives here so the top and any future
// status logic agree on the encoding.
package arcade_input_pkg;

   // Coin acceptor states: waiting for a coin, measuring a low pulse, jammed.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOW   = 2'd1,
      FAULT = 2'd2
   } coinState_t;

   localparam logic [15:0] DEFAULT_DEBOUNCE = 16'd6000;
   localparam logic [23:0] DEFAULT_COIN_MIN = 24'd60000;
   localparam logic [23:0] DEFAULT_COIN_MAX = 24'd600000;

   // Increment an 8-bit total, sticking at 255 instead of wrapping.
   function automatic logic [7:0] satInc8(input logic [7:0] value);
      if (value == 8'hFF) begin
         return value;
      end
      return value + 8'd1;
   endfunction

endpackage

// File: rtl/input_debounce.sv
// One switch channel: two-flop synchronizer, hold-time debouncer and a
// registered press pulse on the debounced falling edge (switches are
// active-low, so falling means pressed).
module input_debounce
   import arcade_input_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE = DEFAULT_DEBOUNCE
) (
   input  logic clk_pix,
   input  logic reset_n,
   input  logic raw_n_i,
   output logic level_n_o,
   output logic pulse_o
);

   logic        sync1_q;
   logic        sync2_q;
   logic        level_q;
   logic        level_d;
   logic        levelDly_q;
   logic        pulse_q;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // The synchronized level must differ from the accepted level for
   // DEBOUNCE consecutive cycles before it is taken; any cycle where it
   // agrees again throws the partial count away.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == DEBOUNCE - 16'd1) begin
            level_d = sync2_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   // Synchronizer presets to released (1) so a reset never looks like a
   // press; the pulse compares the accepted level with its one-cycle-old
   // copy so it appears the edge after the level falls.
   always_ff @(posedge clk_pix or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         level_q    <= 1'b1;
         levelDly_q <= 1'b1;
         pulse_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= raw_n_i;
         sync2_q    <= sync1_q;
         level_q    <= level_d;
         levelDly_q <= level_q;
         pulse_q    <= levelDly_q & ~level_q;
         cnt_q      <= cnt_d;
      end
   end

   assign level_n_o = level_q;
   assign pulse_o   = pulse_q;

endmodule

// File: rtl/arcade_input_cond.sv
// Cabinet/autoplay input conditioner: debounces coin, start and fire,
// produces press pulses for start and fire, and validates coin pulses by
// their low width, keeping a saturating count of accepted coins.
module arcade_input_cond
   import arcade_input_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE = DEFAULT_DEBOUNCE,
   parameter logic [23:0] COIN_MIN = DEFAULT_COIN_MIN,
   parameter logic [23:0] COIN_MAX = DEFAULT_COIN_MAX
) (
   input  logic       clk_pix,
   input  logic       reset_n,
   input  logic       coin_raw_n,
   input  logic       start_raw_n,
   input  logic       throw_raw_n,
   output logic       coin_n,
   output logic       start_n,
   output logic       throw_n,
   output logic       start_pulse,
   output logic       throw_pulse,
   output logic       coin_pulse,
   output logic       coin_fault,
   output logic [7:0] coin_total
);

   logic       coinLevel;
   logic       coinFall_unused;
   coinState_t state_q;
   logic [23:0] wcnt_q;
   logic       coinPulse_q;
   logic       coinFault_q;
   logic [7:0] coinTotal_q;

   input_debounce #(.DEBOUNCE(DEBOUNCE)) uCoin (
      .clk_pix   (clk_pix),
      .reset_n   (reset_n),
      .raw_n_i   (coin_raw_n),
      .level_n_o (coinLevel),
      .pulse_o   (coinFall_unused)
   );

   input_debounce #(.DEBOUNCE(DEBOUNCE)) uStart (
      .clk_pix   (clk_pix),
      .reset_n   (reset_n),
      .raw_n_i   (start_raw_n),
      .level_n_o (start_n),
      .pulse_o   (start_pulse)
   );

   input_debounce #(.DEBOUNCE(DEBOUNCE)) uThrow (
      .clk_pix   (clk_pix),
      .reset_n   (reset_n),
      .raw_n_i   (throw_raw_n),
      .level_n_o (throw_n),
      .pulse_o   (throw_pulse)
   );

   // Coin validation: wcnt counts debounced low cycles starting at 1 on the
   // cycle after the fall. A release is checked before the jam limit, so a
   // coin released on the cycle its count would reach COIN_MAX still
   // counts. A jammed coin is only cleared by its release and never pays.
   always_ff @(posedge clk_pix or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         coinPulse_q <= 1'b0;
         coinFault_q <= 1'b0;
         coinTotal_q <= '0;
      end else begin
         coinPulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!coinLevel) begin
                  state_q <= LOW;
                  wcnt_q  <= 24'd1;
               end
            end
            LOW: begin
               if (coinLevel) begin
                  if (wcnt_q >= COIN_MIN) begin
                     coinPulse_q <= 1'b1;
                     coinTotal_q <= satInc8(coinTotal_q);
                  end
                  state_q <= IDLE;
                  wcnt_q  <= '0;
               end else begin
                  if (wcnt_q != '1) begin
                     wcnt_q <= wcnt_q + 24'd1;
                  end
                  if (wcnt_q >= COIN_MAX - 24'd1) begin
                     state_q     <= FAULT;
                     coinFault_q <= 1'b1;
                  end
               end
            end
            FAULT: begin
               if (coinLevel) begin
                  state_q     <= IDLE;
                  coinFault_q <= 1'b0;
                  wcnt_q      <= '0;
               end
            end
            default: begin
               state_q     <= IDLE;
               coinFault_q <= 1'b0;
               wcnt_q      <= '0;
            end
         endcase
      end
   end

   assign coin_n     = coinLevel;
   assign coin_pulse = coinPulse_q;
   assign coin_fault = coinFault_q;
   assign coin_total = coinTotal_q;

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond with short debounce/coin limits.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_arcade_input_cond;

   logic       clk_pix;
   logic       reset_n;
   logic       coin_raw_n;
   logic       start_raw_n;
   logic       throw_raw_n;
   logic       coin_n;
   logic       start_n;
   logic       throw_n;
   logic       start_pulse;
   logic       throw_pulse;
   logic       coin_pulse;
   logic       coin_fault;
   logic [7:0] coin_total;

   int checks = 0;
   int errors = 0;

   int startPulses   = 0;
   int throwPulses   = 0;
   int coinPulses    = 0;
   int throwLowCount = 0;
   int faultCycles   = 0;

   int baseA;
   int baseB;

   arcade_input_cond #(
      .DEBOUNCE (16'd4),
      .COIN_MIN (24'd20),
      .COIN_MAX (24'd50)
   ) dut (
      .clk_pix     (clk_pix),
      .reset_n     (reset_n),
      .coin_raw_n  (coin_raw_n),
      .start_raw_n (start_raw_n),
      .throw_raw_n (throw_raw_n),
      .coin_n      (coin_n),
      .start_n     (start_n),
      .throw_n     (throw_n),
      .start_pulse (start_pulse),
      .throw_pulse (throw_pulse),
      .coin_pulse  (coin_pulse),
      .coin_fault  (coin_fault),
      .coin_total  (coin_total)
   );

   // 10-unit pixel clock.
   initial begin
      clk_pix = 1'b0;
      forever #5 clk_pix = ~clk_pix;
   end

   // Tally pulse and level activity on the falling edge while out of reset.
   always @(negedge clk_pix) begin
      if (reset_n) begin
         if (start_pulse) startPulses = startPulses + 1;
         if (throw_pulse) throwPulses = throwPulses + 1;
         if (coin_pulse)  coinPulses  = coinPulses + 1;
         if (!throw_n)    throwLowCount = throwLowCount + 1;
         if (coin_fault)  faultCycles = faultCycles + 1;
      end
   end

   task automatic applyStimulus(input logic coin, input logic start, input logic throwIn);
      coin_raw_n  = coin;
      start_raw_n = start;
      throw_raw_n = throwIn;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (observed !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_pix);
      #1;
   endtask

   task automatic coinPress(input int width, input int gap);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitCycles(width);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(gap);
   endtask

   // Watchdog so the run always ends on its own.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitCycles(3);

      // Reset with every input pressed: all levels still released.
      checkOutput("rst_coin_n", coin_n, 1);
      checkOutput("rst_start_n", start_n, 1);
      checkOutput("rst_throw_n", throw_n, 1);
      checkOutput("rst_total", coin_total, 0);
      checkOutput("rst_fault", coin_fault, 0);
      checkOutput("rst_start_pulse", start_pulse, 0);
      checkOutput("rst_coin_pulse", coin_pulse, 0);

      // Release reset: start_n falls on the 6th edge, pulse on the 7th.
      reset_n = 1'b1;
      waitCycles(5);
      checkOutput("rel_start_n_e5", start_n, 1);
      waitCycles(1);
      checkOutput("rel_start_n_e6", start_n, 0);
      checkOutput("rel_pulse_e6", start_pulse, 0);
      waitCycles(1);
      checkOutput("rel_pulse_e7", start_pulse, 1);
      checkOutput("rel_throw_pulse_e7", throw_pulse, 1);
      waitCycles(1);
      checkOutput("rel_pulse_e8", start_pulse, 0);

      // Releasing leaves an 8-cycle coin, which is too short to pay.
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(20);
      checkOutput("rel_start_n_up", start_n, 1);
      checkOutput("rel_start_count", startPulses, 1);
      checkOutput("rel_short_coin_pulses", coinPulses, 0);
      checkOutput("rel_short_coin_total", coin_total, 0);

      // Bounce: low 3 / high 1 never survives a 4-cycle debounce.
      baseA = throwPulses;
      baseB = throwLowCount;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         waitCycles(3);
         applyStimulus(1'b1, 1'b1, 1'b1);
         waitCycles(1);
      end
      waitCycles(10);
      checkOutput("bounce_low_cycles", throwLowCount - baseB, 0);
      checkOutput("bounce_pulses", throwPulses - baseA, 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitCycles(12);
      checkOutput("hold_throw_n", throw_n, 0);
      checkOutput("hold_pulses", throwPulses - baseA, 1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(12);
      checkOutput("release_throw_n", throw_n, 1);
      checkOutput("release_no_pulse", throwPulses - baseA, 1);

      // Valid 30-cycle coin with exact pulse timing.
      baseA = coinPulses;
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitCycles(30);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(5);
      checkOutput("coin30_level_low", coin_n, 0);
      waitCycles(1);
      checkOutput("coin30_level_up", coin_n, 1);
      checkOutput("coin30_pulse_early", coin_pulse, 0);
      checkOutput("coin30_total_early", coin_total, 0);
      waitCycles(1);
      checkOutput("coin30_pulse", coin_pulse, 1);
      checkOutput("coin30_total", coin_total, 1);
      waitCycles(1);
      checkOutput("coin30_pulse_end", coin_pulse, 0);
      waitCycles(10);
      checkOutput("coin30_pulse_count", coinPulses - baseA, 1);

      // Width boundaries: 10 and 19 discarded, 20 and 49 accepted.
      baseA = coinPulses;
      coinPress(10, 15);
      checkOutput("coin10_total", coin_total, 1);
      coinPress(19, 15);
      checkOutput("coin19_total", coin_total, 1);
      checkOutput("coin_short_pulses", coinPulses - baseA, 0);
      coinPress(20, 15);
      checkOutput("coin20_total", coin_total, 2);
      coinPress(49, 15);
      checkOutput("coin49_total", coin_total, 3);
      checkOutput("coin_ok_pulses", coinPulses - baseA, 2);

      // Width 50 reaches the jam limit on the release edge: one fault cycle.
      baseA = coinPulses;
      baseB = faultCycles;
      coinPress(50, 15);
      checkOutput("coin50_total", coin_total, 3);
      checkOutput("coin50_fault_cycles", faultCycles - baseB, 1);
      checkOutput("coin50_pulses", coinPulses - baseA, 0);

      // Jam: 80-cycle hold, fault from width 50 to one cycle after release.
      baseA = coinPulses;
      baseB = faultCycles;
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitCycles(55);
      checkOutput("jam_fault_w49", coin_fault, 0);
      waitCycles(1);
      checkOutput("jam_fault_w50", coin_fault, 1);
      waitCycles(24);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(6);
      checkOutput("jam_fault_at_release", coin_fault, 1);
      waitCycles(1);
      checkOutput("jam_fault_cleared", coin_fault, 0);
      waitCycles(8);
      checkOutput("jam_fault_cycles", faultCycles - baseB, 31);
      checkOutput("jam_pulses", coinPulses - baseA, 0);
      checkOutput("jam_total", coin_total, 3);

      // Saturation: 256 more valid coins, total sticks at 255.
      baseA = coinPulses;
      for (int i = 0; i < 252; i++) begin
         coinPress(20, 12);
      end
      checkOutput("sat_total_reached", coin_total, 255);
      for (int i = 0; i < 4; i++) begin
         coinPress(20, 12);
      end
      checkOutput("sat_total_held", coin_total, 255);
      checkOutput("sat_pulses", coinPulses - baseA, 256);

      // Reset mid-coin: everything clears immediately; held coin is fresh.
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitCycles(30);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_total", coin_total, 0);
      checkOutput("midrst_coin_n", coin_n, 1);
      checkOutput("midrst_fault", coin_fault, 0);
      waitCycles(2);
      reset_n = 1'b1;
      waitCycles(5);
      checkOutput("midrst_coin_n_e5", coin_n, 1);
      waitCycles(1);
      checkOutput("midrst_coin_n_e6", coin_n, 0);
      waitCycles(24);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(12);
      checkOutput("midrst_fresh_coin", coin_total, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
